// File: rtl/sample_wb_if.sv
// Sample packer bus: transfer control, sample stream and RAM write port.
// master drives stimulus/control, slave is the packer itself.
interface sample_wb_if #(
  parameter int ADDR_W = 12
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] num_words;
  logic              wide_mode;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              flush;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [63:0]       wr_data;
  logic              busy;
  logic              done;

  modport master (
    output start, base_addr, num_words, wide_mode, in_valid, in_data, flush,
    input  in_ready, wr_en, wr_addr, wr_data, busy, done
  );

  modport slave (
    input  start, base_addr, num_words, wide_mode, in_valid, in_data, flush,
    output in_ready, wr_en, wr_addr, wr_data, busy, done
  );
endinterface

// File: rtl/sample_wb.sv
// Packs 8-bit samples into 64-bit RAM words (8 narrow or 4 wide lanes) and writes them out.
// Optional early partial-word write on flush: define SAMPLE_WB_FLUSH_EN.
module sample_wb #(
  parameter int ADDR_W = 12
) (
  input logic        clk,
  input logic        rstn,
  sample_wb_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FILL, WRITE, FIN} state_t;

  state_t            state, state_nx;
  logic [2:0]        lane_idx;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] words_left;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [63:0]       packed_w;
  logic [63:0]       packed_nx;
  logic [63:0]       wr_data_q;
  logic              wide_q;
  logic              accept;
  logic              last_lane;
  logic              flush_go;
  logic              to_write;

  assign accept    = (state == FILL) && bus.in_valid;
  assign last_lane = wide_q ? (lane_idx == 3'd3) : (lane_idx == 3'd7);

`ifdef SAMPLE_WB_FLUSH_EN
  assign flush_go = (state == FILL) && bus.flush && (lane_idx != 3'd0);
`else
  logic unused_flush;
  assign unused_flush = bus.flush;
  assign flush_go     = 1'b0;
`endif

  assign to_write = (accept && last_lane) || flush_go;

  // Word as it will look once this cycle's sample (if any) lands in its lane
  always_comb begin
    packed_nx = packed_w;
    if (accept) begin
      for (int unsigned i = 0; i < 8; i++)
        if (!wide_q && lane_idx == 3'(i)) packed_nx[8*i +: 8] = bus.in_data;
      for (int unsigned i = 0; i < 4; i++)
        if (wide_q && lane_idx == 3'(i)) packed_nx[16*i +: 16] = {8'h00, bus.in_data};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (bus.start) state_nx = (bus.num_words != '0) ? FILL : FIN;
      FILL:  if (to_write) state_nx = WRITE;
      WRITE: state_nx = (words_left == ADDR_W'(1)) ? FIN : FILL;
      FIN:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready = (state == FILL);
    bus.wr_en    = (state == WRITE);
    bus.busy     = (state != IDLE);
    bus.done     = (state == FIN);
    bus.wr_addr  = wr_addr_q;
    bus.wr_data  = wr_data_q;
  end

  // Write port registers are loaded on the final acceptance so they stay stable afterwards
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lane_idx   <= '0;
      addr       <= '0;
      words_left <= '0;
      packed_w   <= '0;
      wide_q     <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            addr       <= bus.base_addr;
            words_left <= bus.num_words;
            wide_q     <= bus.wide_mode;
            packed_w   <= '0;
            lane_idx   <= '0;
          end
        end
        FILL: begin
          if (accept) begin
            packed_w <= packed_nx;
            lane_idx <= lane_idx + 3'd1;
          end
          if (to_write) begin
            wr_addr_q <= addr;
            wr_data_q <= packed_nx;
          end
        end
        WRITE: begin
          addr       <= addr + ADDR_W'(1);
          words_left <= words_left - ADDR_W'(1);
          packed_w   <= '0;
          lane_idx   <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sample_wb.sv
// Scoreboard bench for sample_wb: driver pushes expected writes/done pulses, monitor pops and compares.
module tb_sample_wb;
  localparam int AW = 12;

  typedef struct {
    logic [AW-1:0] a;
    logic [63:0]   d;
    int unsigned   c;
  } wr_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  int unsigned cyc = 0;
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  bit          tog = 1'b0;
  wr_t         wr_q[$];
  int unsigned done_q[$];
  logic [7:0]  fixed_q[$];

  sample_wb_if #(.ADDR_W(AW)) bus ();
  sample_wb #(.ADDR_W(AW)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
  endtask

  task automatic flag_fail(input string name);
    n_chk++;
    $display("FAIL %s: event outside expectation (cyc %0d)", name, cyc);
  endtask

  // Monitor: every write / done pulse must match the oldest expectation
  always @(negedge clk) begin
    if (rstn) begin
      if (bus.wr_en) begin
        check("in_ready_in_write", 64'(bus.in_ready), 64'(0));
        if (wr_q.size() == 0) flag_fail("unexpected_write");
        else begin
          wr_t e;
          e = wr_q.pop_front();
          check("wr_addr", 64'(bus.wr_addr), 64'(e.a));
          check("wr_data", bus.wr_data, e.d);
          check("wr_cycle", 64'(cyc), 64'(e.c));
        end
      end
      if (bus.done) begin
        check("in_ready_in_fin", 64'(bus.in_ready), 64'(0));
        if (done_q.size() == 0) flag_fail("unexpected_done");
        else check("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
      end
    end
  end

  task automatic idle_inputs();
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.num_words = '0;
    bus.wide_mode = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.flush     = 1'b0;
  endtask

  // Presents s until accepted; returns at the negedge before the accepting posedge.
  task automatic feed(input logic [7:0] s, input bit gaps, output int unsigned c, output bit ok);
    bit v;
    ok = 1'b0;
    c  = 0;
    for (int unsigned t = 0; t < 40; t++) begin
      v   = gaps ? tog : 1'b1;
      tog = ~tog;
      bus.in_valid  = v;
      bus.in_data   = v ? s : 8'($urandom);
`ifndef SAMPLE_WB_FLUSH_EN
      bus.flush     = 1'($urandom);
`endif
      bus.start     = ($urandom_range(7) == 0);
      bus.base_addr = AW'($urandom);
      bus.num_words = AW'($urandom);
      bus.wide_mode = 1'($urandom);
      c = cyc;
      if (v && bus.in_ready) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
    flag_fail("in_ready_timeout");
  endtask

  task automatic wait_idle();
    for (int unsigned t = 0; t < 20; t++) begin
      if (!bus.busy) return;
      @(negedge clk);
    end
    flag_fail("busy_timeout");
  endtask

  task automatic run_xfer(input logic [AW-1:0] base, input logic [AW-1:0] n,
                          input bit wide, input bit gaps);
    int unsigned lanes;
    logic [63:0] word;
    logic [7:0]  s;
    int unsigned c;
    bit          ok;
    lanes = wide ? 4 : 8;
    @(negedge clk);
    idle_inputs();
    bus.start     = 1'b1;
    bus.base_addr = base;
    bus.num_words = n;
    bus.wide_mode = wide;
    if (n == 0) done_q.push_back(cyc + 1);
    @(negedge clk);
    bus.start = 1'b0;
    for (int unsigned k = 0; k < n; k++) begin
      word = '0;
      for (int unsigned j = 0; j < lanes; j++) begin
        s = (fixed_q.size() != 0) ? fixed_q.pop_front() : 8'($urandom);
        feed(s, gaps, c, ok);
        if (!ok) begin
          idle_inputs();
          return;
        end
        word |= wide ? (64'(s) << (16 * j)) : (64'(s) << (8 * j));
        if (j == lanes - 1) begin
          wr_q.push_back('{base + AW'(k), word, c + 1});
          if (k == n - 1) done_q.push_back(c + 2);
        end
        @(negedge clk);
      end
    end
    idle_inputs();
    wait_idle();
  endtask

  task automatic reset_mid_transfer();
    int unsigned c;
    bit          ok;
    @(negedge clk);
    idle_inputs();
    bus.start     = 1'b1;
    bus.base_addr = 12'h0AB;
    bus.num_words = 12'd1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int unsigned j = 0; j < 3; j++) begin
      feed(8'($urandom), 1'b0, c, ok);
      @(negedge clk);
    end
    idle_inputs();
    rstn = 1'b0;
    #1;
    check("rst_wr_en", 64'(bus.wr_en), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_in_ready", 64'(bus.in_ready), 64'(0));
    check("rst_wr_data", bus.wr_data, 64'(0));
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_stays_idle", 64'(bus.busy), 64'(0));
  endtask

`ifdef SAMPLE_WB_FLUSH_EN
  task automatic flush_partial();
    int unsigned c;
    bit          ok;
    @(negedge clk);
    idle_inputs();
    bus.start     = 1'b1;
    bus.base_addr = 12'h123;
    bus.num_words = 12'd1;
    @(negedge clk);
    bus.start = 1'b0;
    feed(8'hAA, 1'b0, c, ok);
    @(negedge clk);
    feed(8'hBB, 1'b0, c, ok);
    @(negedge clk);
    idle_inputs();
    bus.flush = 1'b1;
    check("flush_in_ready", 64'(bus.in_ready), 64'(1));
    wr_q.push_back('{12'h123, 64'h0000_0000_0000_BBAA, cyc + 1});
    done_q.push_back(cyc + 2);
    @(negedge clk);
    idle_inputs();
    wait_idle();
  endtask
`endif

  initial begin
    idle_inputs();
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(bus.busy), 64'(0));
    check("reset_in_ready", 64'(bus.in_ready), 64'(0));
    check("reset_wr_en", 64'(bus.wr_en), 64'(0));
    check("reset_done", 64'(bus.done), 64'(0));
    rstn = 1'b1;

    fixed_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_xfer(12'h010, 12'd1, 1'b1, 1'b0);

    fixed_q.delete();
    for (int unsigned i = 1; i <= 16; i++) fixed_q.push_back(8'(i));
    run_xfer(12'h200, 12'd2, 1'b0, 1'b0);

    fixed_q.delete();
    for (int unsigned i = 1; i <= 16; i++) fixed_q.push_back(8'(i));
    run_xfer(12'h300, 12'd2, 1'b0, 1'b1);

    fixed_q.delete();
    run_xfer(12'hFFF, 12'd2, 1'b0, 1'b0);
    run_xfer(12'hFFF, 12'd2, 1'b1, 1'b1);
    run_xfer(12'h055, 12'd0, 1'b0, 1'b0);

    reset_mid_transfer();
    run_xfer(12'h0AB, 12'd1, 1'b1, 1'b0);

`ifdef SAMPLE_WB_FLUSH_EN
    flush_partial();
`endif

    for (int unsigned r = 0; r < 10; r++)
      run_xfer(AW'($urandom), AW'($urandom_range(3)), 1'($urandom), 1'($urandom));

    repeat (5) @(negedge clk);
    check("writes_outstanding", 64'(wr_q.size()), 64'(0));
    check("dones_outstanding", 64'(done_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sample_wb.md
SAMPLE_WB -- requirements
Module: sample_wb

Interface
REQ-001 Parameter ADDR_W, default 12, RAM word-address width.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rstn  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle pulse; latches base_addr, num_words, wide_mode.
REQ-005 base_addr  input  ADDR_W  first RAM word address.
REQ-006 num_words  input  ADDR_W  64-bit words to write; 0 means none.
REQ-007 wide_mode  input  1  1 = 16-bit lanes, 4 per word; 0 = 8-bit lanes, 8 per word.
REQ-008 in_valid  input  1  sample byte valid.
REQ-009 in_data  input  8  sample value.
REQ-010 in_ready  output  1  block accepts in_data this cycle.
REQ-011 flush  input  1  force partial-word write (SAMPLE_WB_FLUSH_EN only).
REQ-012 wr_en  output  1  RAM write strobe.
REQ-013 wr_addr  output  ADDR_W  RAM write address.
REQ-014 wr_data  output  64  packed RAM word.
REQ-015 busy  output  1  high from start until done.
REQ-016 done  output  1  one-cycle completion pulse.

Function
REQ-017 States SHALL be IDLE, FILL, WRITE, FIN.
REQ-018 IDLE: start with num_words!=0 -> FILL; start with num_words==0 -> FIN; other inputs ignored.
REQ-019 FILL: in_ready=1; a sample SHALL be accepted on in_valid&&in_ready.
REQ-020 Accepted sample SHALL go to lane lane_idx: wide_mode=1 -> bits [16*lane_idx+15:16*lane_idx] = {8'h00,in_data}; wide_mode=0 -> bits [8*lane_idx+7:8*lane_idx].
REQ-021 lane_idx SHALL clear on entering FILL and increment per acceptance; the acceptance at lane 3 (wide) or lane 7 (narrow) SHALL go to WRITE.
REQ-022 WRITE lasts exactly one cycle: wr_en=1, wr_addr=current address, wr_data=packed word; in_ready=0.
REQ-023 Leaving WRITE: address+1 (wrap modulo 2^ADDR_W); words_left-1; words_left==0 -> FIN, else -> FILL with packed word cleared to 0.
REQ-024 Latency: last sample accepted at cycle N -> wr_en at N+1.
REQ-025 FIN lasts one cycle: done=1, then -> IDLE.
REQ-026 busy SHALL be 1 in FILL, WRITE, FIN; 0 in IDLE.
REQ-027 start outside IDLE SHALL be ignored.
REQ-028 wr_en SHALL be 0 outside WRITE; wr_addr/wr_data hold their last values.
REQ-029 Unused lane bits of a packed word SHALL be 0.

Reset
REQ-030 rstn low SHALL force IDLE, lane_idx=0, address=0, words_left=0, packed word=0, wr_en=0, done=0, busy=0, in_ready=0, mid-transfer included; no pending write survives reset.

Configuration
REQ-031 Macro SAMPLE_WB_FLUSH_EN defined: flush high in FILL with lane_idx!=0 -> WRITE next cycle, remaining lanes 0; simultaneous in_valid sample SHALL be accepted and included; flush with lane_idx==0 ignored.
REQ-032 Macro undefined: flush port present but ignored.

Verification
REQ-033 wide_mode=1, base 0x010, num_words=1, samples 11,22,33,44 -> one wr_en, addr 0x010, data 0x0044_0033_0022_0011, done one cycle later.
REQ-034 wide_mode=0, num_words=2, samples 01..10 -> writes 0x0807060504030201 @base, 0x100F0E0D0C0B0A09 @base+1.
REQ-035 in_valid toggling every other cycle -> same data as continuous stream; in_ready=0 exactly in WRITE cycles.
REQ-036 base_addr=0xFFF, num_words=2, ADDR_W=12 -> second write at 0x000.
REQ-037 num_words=0 -> no wr_en, done one cycle after start; rstn low after 3 samples -> all outputs reset, no write.
REQ-038 SAMPLE_WB_FLUSH_EN, wide_mode=0, samples AA,BB then flush -> wr_data 0x000000000000BBAA.
